assoc_array_store: RTL and testbench
====================================

# assoc_array_store

Hardware key/value store that implements associative-array semantics (`int arr[int]`) for the array-handling datapath. It sits directly upstream of the fixed/dynamic array stages. It accepts read, write, delete and clear requests over a valid/ready channel, searches its entries one per cycle, and returns results over a second valid/ready channel. Its live entry count (`size`) feeds downstream sizing logic.

## Interface
- `KEY_W`, 32, key width in bits.
- `DATA_W`, 32, value width in bits.
- `DEPTH`, 8, number of entries; legal range 2..64.

Reset and clock: one clock; reset is asynchronous and active-low.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: store can accept a request; high only in IDLE.
- `req_op` in 2: request opcode.
  - 00 = READ, 01 = WRITE, 10 = DELETE, 11 = CLEAR.
- `req_key` in KEY_W: lookup key; ignored for CLEAR.
- `req_data` in DATA_W: write value; used only for WRITE.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_hit` out 1: key was present before the operation.
- `rsp_data` out DATA_W: value read; 0 on a miss or for any non-READ operation.
- `rsp_err` out 1: WRITE miss while the store is full.
- `size` out $clog2(DEPTH+1): count of valid entries.

## Operation
- Storage:
  - Per entry: `valid`, `key`, `data`.
  - Only the `valid` bits are reset. Key and data storage is not reset.
  - Keys are unique; at most one valid entry matches a given key.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch op/key/data.
  - CLEAR goes to RESP. All other ops go to SCAN with index `k`=0 and no free slot recorded.
- SCAN, one entry per cycle:
  - Compare entry `k` (valid and key equal).
  - Record the lowest-index invalid entry seen so far as the free slot.
  - On a hit, or when `k`=DEPTH-1, commit the operation at that edge and go to RESP. Otherwise increment `k`.
- Commit rules:
  - READ hit: `rsp_data` = entry data, `rsp_hit`=1. READ miss: `rsp_data`=0, `rsp_hit`=0.
  - WRITE hit: overwrite data, `rsp_hit`=1; `size` unchanged.
  - WRITE miss with a free slot: store into the lowest free index, set valid, `size`+1, `rsp_hit`=0.
  - WRITE miss with no free slot: no state change, `rsp_err`=1.
  - DELETE hit: clear valid, `size`-1, `rsp_hit`=1. DELETE miss: no change, `rsp_hit`=0.
  - CLEAR: all valid bits cleared, `size`=0, `rsp_hit`=0. CLEAR commits on its accept edge.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- Free-slot tracking:
  - A write miss scans all DEPTH entries.
  - Free slots are found on the same pass, so no second scan is needed.
- Arithmetic: `size` never exceeds DEPTH and never underflows; invariant `size` = popcount(valid).
- Reset values:
  - FSM = IDLE, `req_ready`=1.
  - `rsp_valid`, `rsp_hit`, `rsp_err`, `rsp_data`, `size` all 0.
  - All valid bits 0.

## Timing
- Accept edge = E0.
- Latency for READ/WRITE/DELETE:
  - Entry `k` is compared in the cycle after edge E0+k.
  - A hit at index `k` gives `rsp_valid` high from cycle E0+k+2.
  - A miss gives `rsp_valid` high from E0+DEPTH+1.
- CLEAR: `rsp_valid` high at E0+1.
- At most one request in flight; `req_ready`=0 from E0 until the response handshake edge.
- Next accept: earliest on the cycle after the response handshake, i.e. a request presented in the first IDLE cycle is accepted.
- `size` updates at the commit edge and is visible on the same cycle `rsp_valid` rises.
- Reset asserted mid-SCAN or in RESP:
  - Immediately returns to reset values.
  - Any uncommitted operation is discarded; any committed operation's data is lost along with the valid bits.
- No combinational path from `req_*` to any output; `req_ready` depends on state only.

## Test plan
- **Reset then read.** Reset, then READ key 80 -> `rsp_valid` at E0+DEPTH+1 (cycle 9 for DEPTH=8), `rsp_hit`=0, `rsp_data`=0, `size`=0.
- **Insert and lookup.**
  - WRITE 80->81, then WRITE 0->1 -> `size`=2, both `rsp_hit`=0.
  - READ 0 -> hit at index 1, `rsp_valid` at E0+3, `rsp_data`=1.
  - WRITE 80->99 then READ 80 -> `rsp_hit`=1, `rsp_data`=99, `size`=2.
- **Full store.**
  - WRITE keys 0..7 -> `size`=8.
  - WRITE key 50 -> `rsp_err`=1, `size`=8.
  - DELETE key 3 -> `rsp_hit`=1, `size`=7.
  - WRITE key 50 -> placed at index 3; a subsequent READ 50 responds at E0+5.
- **Backpressure.** Hold `rsp_ready`=0 for 10 cycles after a READ hit -> `rsp_*` stable, `req_ready`=0 throughout; a response handshake is then followed by a new accept on the next cycle.
- **Clear.** After 5 entries, CLEAR -> `rsp_valid` at E0+1, `size`=0; READ of any prior key misses.
- **Reset mid-operation.** Assert `rst_n`=0 during SCAN of a WRITE -> outputs at reset values, `size`=0, no response ever issued for that request.

Source files
------------

// File: rtl/assoc_array_store.sv
// assoc_array_store: key/value store with associative-array semantics, linear one-entry-per-cycle scan.
// Free slot is tracked during the scan so a write miss needs only a single pass.
module assoc_array_store #(
    parameter int KEY_W  = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [KEY_W-1:0]           req_key,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_hit,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH+1)-1:0] size
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH+1);
    localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_RESP = 2'd2;
    localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_DEL = 2'd2, OP_CLR = 2'd3;

    logic [1:0]        r_state, r_op;
    logic [KEY_W-1:0]  r_key_q;
    logic [DATA_W-1:0] r_data_q;
    logic [IW-1:0]     r_k, r_free_idx;
    logic              r_free_vld;
    logic [DEPTH-1:0]  r_valid;
    logic [KEY_W-1:0]  r_key [DEPTH];
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SW-1:0]     r_size;
    logic              r_hit, r_err;
    logic [DATA_W-1:0] r_rdata;

    logic          w_acc, w_hit, w_last, w_commit, w_has_free, w_ins, w_upd;
    logic [IW-1:0] w_fidx;

    always_comb begin
        w_acc      = req_valid && r_state == S_IDLE;
        w_hit      = r_valid[r_k] && r_key[r_k] == r_key_q;
        w_last     = r_k == IW'(DEPTH-1);
        w_commit   = r_state == S_SCAN && (w_hit || w_last);
        // the entry under the comparator counts as free if nothing lower was found
        w_has_free = r_free_vld || !r_valid[r_k];
        w_fidx     = r_free_vld ? r_free_idx : r_k;
        w_ins      = w_commit && r_op == OP_WR && !w_hit && w_has_free;
        w_upd      = w_commit && r_op == OP_WR && w_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_RD;
            r_key_q    <= '0;
            r_data_q   <= '0;
            r_k        <= '0;
            r_free_idx <= '0;
            r_free_vld <= 1'b0;
            r_valid    <= '0;
            r_size     <= '0;
            r_hit      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_acc) begin
                r_op       <= req_op;
                r_key_q    <= req_key;
                r_data_q   <= req_data;
                r_k        <= '0;
                r_free_vld <= 1'b0;
                r_hit      <= 1'b0;
                r_err      <= 1'b0;
                r_rdata    <= '0;
                r_state    <= req_op == OP_CLR ? S_RESP : S_SCAN;
                if (req_op == OP_CLR) begin
                    r_valid <= '0;
                    r_size  <= '0;
                end
            end
            if (r_state == S_SCAN) begin
                if (!r_free_vld && !r_valid[r_k]) begin
                    r_free_vld <= 1'b1;
                    r_free_idx <= r_k;
                end
                if (w_hit || w_last) begin
                    r_state <= S_RESP;
                    r_hit   <= w_hit;
                    r_rdata <= (r_op == OP_RD && w_hit) ? r_mem[r_k] : '0;
                    r_err   <= r_op == OP_WR && !w_hit && !w_has_free;
                    if (w_ins) begin
                        r_valid[w_fidx] <= 1'b1;
                        r_size          <= r_size + 1'b1;
                    end
                    if (r_op == OP_DEL && w_hit) begin
                        r_valid[r_k] <= 1'b0;
                        r_size       <= r_size - 1'b1;
                    end
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
            if (r_state == S_RESP && rsp_ready)
                r_state <= S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ins) begin
            r_key[w_fidx] <= r_key_q;
            r_mem[w_fidx] <= r_data_q;
        end
        if (w_upd)
            r_mem[r_k] <= r_data_q;
    end

    assign req_ready = r_state == S_IDLE;
    assign rsp_valid = r_state == S_RESP;
    assign rsp_hit   = r_hit;
    assign rsp_err   = r_err;
    assign rsp_data  = r_rdata;
    assign size      = r_size;
endmodule

// File: tb/tb_assoc_array_store.sv
// tb_assoc_array_store: directed-vector bench for assoc_array_store (DEPTH=8).
module tb_assoc_array_store;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, DEL = 2'd2, CLR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_key = '0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_hit;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  size;

    int checks = 0;
    int errors = 0;

    assoc_array_store #(.KEY_W(32), .DATA_W(32), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .size(size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // lat counts cycles from the accept edge: 1 = rsp_valid right after E0
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] key,
                         input logic [31:0] data, input int elat, input logic ehit,
                         input logic [31:0] edata, input logic eerr, input logic [3:0] esize,
                         input bit ack);
        int n;
        int lat;
        req_op = op; req_key = key; req_data = data; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_hit"}, rsp_hit, ehit);
        check({tag, "_data"}, rsp_data, edata);
        check({tag, "_err"}, rsp_err, eerr);
        check({tag, "_size"}, size, esize);
        if (ack) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_valid", rsp_valid, 0);
        check("rst_hit", rsp_hit, 0);
        check("rst_err", rsp_err, 0);
        check("rst_data", rsp_data, 0);
        check("rst_size", size, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("rd80_empty", RD, 80, 0, 9, 0, 0, 0, 0, 1);
        do_op("wr80", WR, 80, 81, 9, 0, 0, 0, 1, 1);
        do_op("wr0", WR, 0, 1, 9, 0, 0, 0, 2, 1);
        do_op("rd0", RD, 0, 0, 3, 1, 1, 0, 2, 1);
        do_op("wr80_upd", WR, 80, 99, 2, 1, 0, 0, 2, 1);
        do_op("rd80", RD, 80, 0, 2, 1, 99, 0, 2, 1);

        do_op("clr0", CLR, 0, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            do_op($sformatf("fill%0d", i), WR, i, 100 + i, 9, 0, 0, 0, 4'(i + 1), 1);
        do_op("wr50_full", WR, 50, 55, 9, 0, 0, 1, 8, 1);
        do_op("del3", DEL, 3, 0, 5, 1, 0, 0, 7, 1);
        do_op("del3_again", DEL, 3, 0, 9, 0, 0, 0, 7, 1);
        do_op("wr50", WR, 50, 55, 9, 0, 0, 0, 8, 1);
        do_op("rd50", RD, 50, 0, 5, 1, 55, 0, 8, 1);
        do_op("rd7", RD, 7, 0, 9, 1, 107, 0, 8, 1);

        do_op("rd5_bp", RD, 5, 0, 7, 1, 105, 0, 8, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_ready", req_ready, 0);
            check("bp_hit", rsp_hit, 1);
            check("bp_data", rsp_data, 105);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_idle_ready", req_ready, 1);
        check("bp_idle_valid", rsp_valid, 0);
        do_op("rd6_next", RD, 6, 0, 8, 1, 106, 0, 8, 1);

        do_op("clr1", CLR, 0, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            do_op($sformatf("five%0d", i), WR, 10 + i, 200 + i, 9, 0, 0, 0, 4'(i + 1), 1);
        do_op("clr5", CLR, 0, 0, 1, 0, 0, 0, 0, 1);
        do_op("rd12_clr", RD, 12, 0, 9, 0, 0, 0, 0, 1);

        do_op("wr30", WR, 30, 300, 9, 0, 0, 0, 1, 1);
        req_op = WR; req_key = 31; req_data = 310; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_scan_busy", req_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", req_ready, 1);
        check("mrst_valid", rsp_valid, 0);
        check("mrst_hit", rsp_hit, 0);
        check("mrst_err", rsp_err, 0);
        check("mrst_data", rsp_data, 0);
        check("mrst_size", size, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (rsp_valid) seen++;
            end
            check("mrst_no_rsp", seen, 0);
        end
        do_op("rd30_lost", RD, 30, 0, 9, 0, 0, 0, 0, 1);
        do_op("rd31_lost", RD, 31, 0, 9, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
